// File: rtl/iou_pkg.sv
// Shared types and bit indices for the programmed-I/O and interrupt-flag unit.
package iou_pkg;

  typedef enum logic [1:0] {
    IN_EMPTY = 2'd0,
    IN_ONE   = 2'd1,
    IN_FULL  = 2'd2
  } in_state_e;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_PEND  = 1'b1
  } out_state_e;

  localparam int STAT_IN_UNF  = 0;
  localparam int STAT_OUT_OVF = 1;

  localparam int CFG_I_EN = 0;
  localparam int CFG_O_EN = 1;
  localparam int CFG_GIE  = 2;

endpackage

// File: rtl/iou_in_buf.sv
// Input character buffer feeding INPR: single entry by default, 2-entry FIFO
// when IOU_IN_BUF2_EN is defined. Caller must not push when full or pop when empty.
module iou_in_buf
  import iou_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [CW-1:0] i_data,
  output logic [CW-1:0] o_head,
  output logic          o_empty,
  output logic          o_full
);

  in_state_e     r_state;
  logic [CW-1:0] r_mem0;

`ifdef IOU_IN_BUF2_EN
  logic [CW-1:0] r_mem1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IN_EMPTY;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      case (r_state)
        IN_EMPTY: if (i_push) begin
          r_mem0  <= i_data;
          r_state <= IN_ONE;
        end
        IN_ONE: begin
          // simultaneous push/pop replaces the head and keeps one entry
          if (i_push && i_pop) begin
            r_mem0 <= i_data;
          end else if (i_push) begin
            r_mem1  <= i_data;
            r_state <= IN_FULL;
          end else if (i_pop) begin
            r_state <= IN_EMPTY;
          end
        end
        IN_FULL: if (i_pop) begin
          r_mem0  <= r_mem1;
          r_state <= IN_ONE;
        end
        default: r_state <= IN_EMPTY;
      endcase
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IN_EMPTY;
      r_mem0  <= '0;
    end else begin
      case (r_state)
        IN_EMPTY: if (i_push) begin
          r_mem0  <= i_data;
          r_state <= IN_FULL;
        end
        IN_FULL: if (i_pop) r_state <= IN_EMPTY;
        default: r_state <= IN_EMPTY;
      endcase
    end
  end
`endif

  assign o_head  = r_mem0;
  assign o_empty = (r_state == IN_EMPTY);
  assign o_full  = (r_state == IN_FULL);

endmodule

// File: rtl/io_interrupt_unit.sv
// Programmed-I/O and interrupt-flag unit: control register, OUTR handshake FSM,
// INPR bus drive and sticky status. Input buffer depth follows IOU_IN_BUF2_EN.
module io_interrupt_unit
  import iou_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cfg_we,
  input  logic [2:0]    cfg_wdata,
  input  logic          inpr_read,
  input  logic          outr_write,
  input  logic [DW-1:0] bus_in,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  output logic          GIE,
  output logic          I_en,
  output logic          O_en,
  output logic          I_flag,
  output logic          O_flag,
  input  logic          dev_in_valid,
  input  logic [CW-1:0] dev_in_data,
  output logic          dev_in_ready,
  output logic          dev_out_valid,
  output logic [CW-1:0] dev_out_data,
  input  logic          dev_out_ready,
  output logic [1:0]    status
);

  logic [2:0]    r_cfg;
  logic [1:0]    r_status;
  out_state_e    r_out_state;
  logic [CW-1:0] r_outr;
  logic [DW-1:0] r_bus_out;
  logic          r_bus_oe;

  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_head;
  logic          w_empty;
  logic          w_full;
  logic [1:0]    w_status_nxt;

  assign w_push = dev_in_valid & ~w_full;
  assign w_pop  = inpr_read & ~w_empty;

  iou_in_buf #(.CW(CW)) u_in_buf (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (dev_in_data),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  always_ff @(posedge clk) begin
    if (rst) r_cfg <= '0;
    else if (cfg_we) r_cfg <= cfg_wdata;
  end

  // a cfg write of all zeros doubles as the status clear; same-cycle events still latch
  always_comb begin
    w_status_nxt = (cfg_we && cfg_wdata == 3'b000) ? 2'b00 : r_status;
    if (inpr_read && w_empty) w_status_nxt[STAT_IN_UNF] = 1'b1;
    if (outr_write && r_out_state == OUT_PEND && !dev_out_ready)
      w_status_nxt[STAT_OUT_OVF] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) r_status <= '0;
    else     r_status <= w_status_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_out <= '0;
      r_bus_oe  <= 1'b0;
    end else begin
      r_bus_oe  <= inpr_read;
      r_bus_out <= w_pop ? DW'(w_head) : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_state <= OUT_EMPTY;
      r_outr      <= '0;
    end else begin
      case (r_out_state)
        OUT_EMPTY: if (outr_write) begin
          r_outr      <= bus_in[CW-1:0];
          r_out_state <= OUT_PEND;
        end
        OUT_PEND: begin
          // drain and refill in one cycle: stay pending with the new character
          if (dev_out_ready && outr_write) r_outr <= bus_in[CW-1:0];
          else if (dev_out_ready)          r_out_state <= OUT_EMPTY;
        end
        default: r_out_state <= OUT_EMPTY;
      endcase
    end
  end

  generate
    if (DW > CW) begin : g_bus_hi
      logic w_unused_bus_hi;
      assign w_unused_bus_hi = ^bus_in[DW-1:CW];
    end
  endgenerate

  assign GIE           = r_cfg[CFG_GIE];
  assign O_en          = r_cfg[CFG_O_EN];
  assign I_en          = r_cfg[CFG_I_EN];
  assign I_flag        = ~w_empty;
  assign dev_in_ready  = ~w_full;
  assign O_flag        = (r_out_state == OUT_EMPTY);
  assign dev_out_valid = (r_out_state == OUT_PEND);
  assign dev_out_data  = r_outr;
  assign bus_out       = r_bus_out;
  assign bus_oe        = r_bus_oe;
  assign status        = r_status;

endmodule

// File: doc/io_interrupt_unit.md
# io_interrupt_unit

Programmed-I/O and interrupt-flag unit for the accumulator CPU. Sits directly upstream of the control sequencer and supplies `GIE`, `I_en`, `O_en`, `I_flag` and `O_flag`. It answers the sequencer's `inpr_read` and `outr_write` strobes by driving the input register (INPR) onto the data bus or capturing the bus into the output register (OUTR). It also performs valid/ready handshakes with an external character device on both sides.

## Interface
- `DW`, 16: data bus width.
- `CW`, 8: character width; INPR/OUTR width, with CW ≤ DW.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  system clock.
  - `rst`  in  1  synchronous, active-high reset.
- `cfg_we`  in  1  write enable for the control register.
- `cfg_wdata`  in  3  {GIE, O_en, I_en}.
- `inpr_read`  in  1  sequencer strobe: pop INPR onto the bus.
- `outr_write`  in  1  sequencer strobe: capture the bus into OUTR.
- `bus_in`  in  DW  data bus.
- `bus_out`  out  DW  zero-extended INPR data.
- `bus_oe`  out  1  `bus_out` is valid this cycle.
- `GIE`, `I_en`, `O_en`  out  1 each  control register bits.
- `I_flag`  out  1  input buffer non-empty.
- `O_flag`  out  1  OUTR empty, ready for a new character.
- `dev_in_valid`, `dev_in_data[CW]`  in  device → INPR.
- `dev_in_ready`  out  1  INPR can accept a character.
- `dev_out_valid`  out  1  OUTR holds a character for the device.
- `dev_out_data`  out  CW  OUTR contents.
- `dev_out_ready`  in  1  device accepts the character.
- `status`  out  2  sticky {out_ovf, in_unf}.

## Operation
- **Control register:** on `cfg_we`, {GIE, O_en, I_en} ← `cfg_wdata`. This has priority over nothing; it is an independent register.
- **Input FSM:** states IN_EMPTY and IN_FULL.
  - Push on `dev_in_valid & dev_in_ready`.
  - `dev_in_ready` = state ≠ IN_FULL (registered).
  - `I_flag` = state ≠ IN_EMPTY (registered).
- **Pop:** `inpr_read` sampled high pops the head. On the next cycle `bus_out` = {0, head} and `bus_oe` = 1, for exactly one cycle.
- **Input underrun:** `inpr_read` in IN_EMPTY gives `bus_out` = 0, `bus_oe` = 1, sets sticky `in_unf`, and leaves the state unchanged.
- **Output FSM:** states OUT_EMPTY and OUT_PEND.
  - `outr_write` in OUT_EMPTY: OUTR ← `bus_in[CW-1:0]`, go to OUT_PEND.
  - In OUT_PEND, `dev_out_valid` = 1. `dev_out_ready` returns to OUT_EMPTY.
  - `O_flag` = (state == OUT_EMPTY).
- **Output overrun:** `outr_write` in OUT_PEND is ignored, OUTR is unchanged, and sticky `out_ovf` is set.
- **Simultaneous events:**
  - In OUT_PEND, `outr_write` together with `dev_out_ready`: the drain completes first and the new character is captured. Net state stays OUT_PEND with new data, and no overflow is flagged.
  - Push and pop in the same cycle: the pop takes the old head and the push stores the new character.
- **Status:** sticky bits clear only on `rst`, or on `cfg_we` with `cfg_wdata` = 3'b000.
- **Software rule:** while GIE & O_en & O_flag, the sequencer stays in its output-interrupt path. Software must clear O_en when it has nothing to send.

## Timing
- **Reset values:**
  - GIE, I_en, O_en, I_flag, `bus_oe`, `dev_out_valid`, `status` = 0.
  - `bus_out`, `dev_out_data` = 0.
  - O_flag = 1, `dev_in_ready` = 1.
  - FSMs in IN_EMPTY / OUT_EMPTY.
- **Latencies:**
  - Device push to I_flag high: 1 cycle.
  - `inpr_read` to `bus_oe`: 1 cycle. This aligns with the sequencer's `ac_write` cycle.
  - `outr_write` to `dev_out_valid`: 1 cycle.
  - `dev_out_ready` to O_flag high: 1 cycle.
- **Handshakes:** `dev_out_valid` and `dev_out_data` hold stable until accepted. `dev_in_data` is sampled only on the handshake edge.
- **Reset mid-transfer:** any pending OUTR character or buffered input is discarded with no handshake.

## Configuration
- **`IOU_IN_BUF2_EN` defined:** the input buffer is a 2-entry FIFO with states IN_EMPTY, IN_ONE and IN_FULL.
  - `dev_in_ready` stays high in IN_ONE.
  - Push and pop together in IN_ONE stay in IN_ONE.
  - Pop order is FIFO.
- **`IOU_IN_BUF2_EN` undefined:** single-entry INPR with only IN_EMPTY and IN_FULL.
- All other behaviour is identical in both builds.

## Structure
- `iou_pkg`: input and output state enums, status bit indices, cfg bit indices (GIE=2, O_en=1, I_en=0).
- One sub-module, `iou_in_buf`: the 1- or 2-entry input buffer with push/pop, head data and occupancy. It holds the macro-dependent logic.
- Top level: control register, output FSM and bus drive.

## Test plan
- **Reset:** assert `rst` for 2 cycles → O_flag=1, `dev_in_ready`=1, all other outputs 0.
- **Input path:** device pushes 8'h41, then `inpr_read` pulse → I_flag=1 one cycle after the push. `bus_out`=16'h0041 with `bus_oe`=1 one cycle after the strobe. I_flag=0 after the pop.
- **Output path:** `bus_in`=16'h1234, `outr_write` → `dev_out_data`=8'h34, `dev_out_valid`=1. Hold `dev_out_ready` low for 5 cycles (data stable), then raise it → O_flag=1 the next cycle.
- **Overrun and underrun:** `outr_write` twice while `dev_out_ready`=0 → out_ovf=1, first character retained. `inpr_read` when empty → `bus_out`=0, in_unf=1. `cfg_we` with 3'b000 clears both.
- **Buffer depth (with `IOU_IN_BUF2_EN`):** push 8'h01 and 8'h02 → `dev_in_ready`=0. Two pops → bus shows 0x01 then 0x02. In the build without the macro, `dev_in_ready`=0 after the first push.
- **Reset mid-operation:** OUT_PEND with data, and input full, then `rst` → `dev_out_valid`=0, I_flag=0, O_flag=1 on the next cycle.
